// File: rtl/icu_sequencer.sv
// Program sequencer for the ICU: owns the program counter, fetches {opcode, operand} from
// an async-read ROM, and handles jump, call/return through a return stack, halt and run/step.
module icu_sequencer #(
  parameter int PC_W    = 8,
  parameter int IO_W    = 8,
  parameter int STACK_D = 4,
  localparam int SP_W   = $clog2(STACK_D + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic              halt_req,
  output logic [PC_W-1:0]   prog_addr,
  input  logic [IO_W+3:0]   prog_data,
  output logic [3:0]        i,
  output logic [IO_W-1:0]   io_addr,
  input  logic              jmp,
  input  logic              rtn,
  input  logic              flag_o,
  input  logic              flag_f,
  output logic              running,
  output logic              halted,
  output logic              err,
  output logic [SP_W-1:0]   sp
);

  localparam int         IDX_W   = (STACK_D > 1) ? $clog2(STACK_D) : 1;
  localparam logic [3:0] OP_NOPO = 4'h0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              call_pend_q, call_pend_d;
  logic              halted_q, halted_d;
  logic [PC_W-1:0]   stack_q [STACK_D];

  logic              exec;
  logic              push;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   target;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;

  assign exec     = (state_q == S_RUN) || (state_q == S_STEP);
  assign pc_inc   = pc_q + 1'b1;
  assign target   = prog_data[PC_W-1:0];
  assign push_idx = sp_q[IDX_W-1:0];
  assign pop_idx  = IDX_W'(sp_q - 1'b1);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    sp_d        = sp_q;
    call_pend_d = 1'b0;
    halted_d    = halted_q;
    push        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!halt_req) begin
          if (start) begin
            state_d  = S_RUN;
            halted_d = 1'b0;
          end else if (step) begin
            state_d  = S_STEP;
            halted_d = 1'b0;
          end
        end
      end

      S_ERR: begin
        if (start) begin
          state_d  = S_RUN;
          pc_d     = '0;
          sp_d     = '0;
          halted_d = 1'b0;
        end
      end

      default: begin
        // A NOPO in this cycle turns a JMP in the next cycle into a call.
        call_pend_d = flag_o;
        if (state_q == S_STEP || halt_req) state_d = S_IDLE;

        if (rtn) begin
          if (sp_q == '0) begin
            state_d = S_ERR;
          end else begin
            pc_d = stack_q[pop_idx];
            sp_d = sp_q - 1'b1;
          end
        end else if (jmp && call_pend_q) begin
          if (sp_q == SP_W'(STACK_D)) begin
            state_d = S_ERR;
          end else begin
            push = 1'b1;
            sp_d = sp_q + 1'b1;
            pc_d = target;
          end
        end else if (jmp) begin
          pc_d = target;
        end else if (flag_f) begin
          pc_d     = pc_inc;
          state_d  = S_IDLE;
          halted_d = 1'b1;
        end else begin
          pc_d = pc_inc;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      sp_q        <= '0;
      call_pend_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      sp_q        <= sp_d;
      call_pend_q <= call_pend_d;
      halted_q    <= halted_d;
    end
  end

  // NOTE: the stack array has no reset; only entries below sp are ever read.
  always_ff @(posedge clk) begin
    if (push) stack_q[push_idx] <= pc_inc;
  end

  assign prog_addr = pc_q;
  assign i         = exec ? prog_data[IO_W+3:IO_W] : OP_NOPO;
  assign io_addr   = exec ? prog_data[IO_W-1:0] : '0;
  assign running   = exec;
  assign halted    = halted_q;
  assign err       = (state_q == S_ERR);
  assign sp        = sp_q;

endmodule

// File: tb/tb_icu_sequencer.sv
// Directed bench for icu_sequencer: a ROM array and a decode-only ICU model drive the DUT;
// one 8-bit-PC instance covers run/call/error/step, a 4-bit-PC instance covers wrap and reset.
module tb_icu_sequencer;

  localparam logic [3:0] OP_NOPO = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_STO  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RTN  = 4'hD;
  localparam logic [3:0] OP_NOPF = 4'hF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 8-bit PC instance
  logic        start, step, halt_req;
  logic [7:0]  prog_addr;
  logic [11:0] prog_data;
  logic [3:0]  i;
  logic [7:0]  io_addr;
  logic        jmp, rtn, flag_o, flag_f;
  logic        running, halted, err;
  logic [2:0]  sp;
  logic [11:0] rom [256];

  assign prog_data = rom[prog_addr];
  assign jmp       = (i == OP_JMP);
  assign rtn       = (i == OP_RTN);
  assign flag_o    = (i == OP_NOPO);
  assign flag_f    = (i == OP_NOPF);

  icu_sequencer #(.PC_W(8), .IO_W(8), .STACK_D(4)) dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .halt_req(halt_req),
    .prog_addr(prog_addr), .prog_data(prog_data), .i(i), .io_addr(io_addr),
    .jmp(jmp), .rtn(rtn), .flag_o(flag_o), .flag_f(flag_f),
    .running(running), .halted(halted), .err(err), .sp(sp)
  );

  // 4-bit PC instance
  logic        start4, step4, halt_req4;
  logic [3:0]  prog_addr4;
  logic [11:0] prog_data4;
  logic [3:0]  i4;
  logic [7:0]  io_addr4;
  logic        jmp4, rtn4, flag_o4, flag_f4;
  logic        running4, halted4, err4;
  logic [2:0]  sp4;
  logic [11:0] rom4 [16];

  assign prog_data4 = rom4[prog_addr4];
  assign jmp4       = (i4 == OP_JMP);
  assign rtn4       = (i4 == OP_RTN);
  assign flag_o4    = (i4 == OP_NOPO);
  assign flag_f4    = (i4 == OP_NOPF);

  icu_sequencer #(.PC_W(4), .IO_W(8), .STACK_D(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .step(step4), .halt_req(halt_req4),
    .prog_addr(prog_addr4), .prog_data(prog_data4), .i(i4), .io_addr(io_addr4),
    .jmp(jmp4), .rtn(rtn4), .flag_o(flag_o4), .flag_f(flag_f4),
    .running(running4), .halted(halted4), .err(err4), .sp(sp4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       start;
    logic [7:0] pc;
    logic [3:0] op;
    logic [7:0] io;
    logic       run;
    logic       hlt;
    logic [2:0] sp;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rom();
    for (int a = 0; a < 256; a++) rom[a] = {OP_LD, 8'h00};
    for (int a = 0; a < 16; a++) rom4[a] = {OP_LD, 8'h00};
  endtask

  task automatic do_reset();
    start = 0; step = 0; halt_req = 0;
    start4 = 0; step4 = 0; halt_req4 = 0;
    rst = 0;
    #2;
    rst = 1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 0;
    start = 0; step = 0; halt_req = 0;
    start4 = 0; step4 = 0; halt_req4 = 0;
    fill_rom();

    // {start, pc, opcode, io_addr, running, halted, sp}, sampled before the clock edge
    tbl[0] = '{1'b0, 8'd0, OP_NOPO, 8'h00, 1'b0, 1'b0, 3'd0};
    tbl[1] = '{1'b1, 8'd0, OP_NOPO, 8'h00, 1'b0, 1'b0, 3'd0};
    tbl[2] = '{1'b0, 8'd0, OP_LD,   8'h03, 1'b1, 1'b0, 3'd0};
    tbl[3] = '{1'b0, 8'd1, OP_OR,   8'h04, 1'b1, 1'b0, 3'd0};
    tbl[4] = '{1'b0, 8'd2, OP_STO,  8'h05, 1'b1, 1'b0, 3'd0};
    tbl[5] = '{1'b0, 8'd3, OP_NOPF, 8'h00, 1'b1, 1'b0, 3'd0};
    tbl[6] = '{1'b0, 8'd4, OP_NOPO, 8'h00, 1'b0, 1'b1, 3'd0};

    #3 rst = 1;
    tick();

    // Straight-line program ending in NOPF
    rom[0] = {OP_LD, 8'h03};
    rom[1] = {OP_OR, 8'h04};
    rom[2] = {OP_STO, 8'h05};
    rom[3] = {OP_NOPF, 8'h00};
    rom[4] = {OP_LD, 8'h09};
    for (int k = 0; k < 7; k++) begin
      start = tbl[k].start;
      check($sformatf("t1_pc[%0d]", k), prog_addr, tbl[k].pc);
      check($sformatf("t1_i[%0d]", k), i, tbl[k].op);
      check($sformatf("t1_io[%0d]", k), io_addr, tbl[k].io);
      check($sformatf("t1_run[%0d]", k), running, tbl[k].run);
      check($sformatf("t1_halted[%0d]", k), halted, tbl[k].hlt);
      check($sformatf("t1_err[%0d]", k), err, 1'b0);
      check($sformatf("t1_sp[%0d]", k), sp, tbl[k].sp);
      tick();
    end

    // Plain jump
    do_reset();
    fill_rom();
    rom[0]   = {OP_JMP, 8'h20};
    rom[32]  = {OP_LD, 8'h07};
    rom[33]  = {OP_NOPF, 8'h00};
    start = 1; tick(); start = 0;
    check("t2_i_jmp", i, OP_JMP);
    tick();
    check("t2_pc_target", prog_addr, 8'h20);
    check("t2_sp", sp, 3'd0);
    check("t2_io", io_addr, 8'h07);
    tick(); tick();
    check("t2_halted", halted, 1'b1);
    check("t2_pc_after", prog_addr, 8'h22);

    // Call and return, then return with empty stack
    do_reset();
    fill_rom();
    rom[0]  = {OP_NOPO, 8'h00};
    rom[1]  = {OP_JMP, 8'h40};
    rom[64] = {OP_RTN, 8'h00};
    rom[2]  = {OP_RTN, 8'h00};
    start = 1; tick(); start = 0;
    check("t3_pc0", prog_addr, 8'd0);
    tick();
    check("t3_i_jmp", i, OP_JMP);
    tick();
    check("t3_pc_sub", prog_addr, 8'h40);
    check("t3_sp_call", sp, 3'd1);
    check("t3_stack0", dut.stack_q[0], 8'd2);
    tick();
    check("t3_pc_ret", prog_addr, 8'd2);
    check("t3_sp_ret", sp, 3'd0);
    tick();
    check("t3_err_underflow", err, 1'b1);
    check("t3_pc_hold", prog_addr, 8'd2);
    check("t3_i_err", i, OP_NOPO);
    check("t3_run_err", running, 1'b0);
    start = 1; tick(); start = 0;
    check("t3_err_clr", err, 1'b0);
    check("t3_pc_restart", prog_addr, 8'd0);
    check("t3_run_restart", running, 1'b1);
    halt_req = 1; tick(); halt_req = 0;
    check("t3_halt_req_run", running, 1'b0);
    check("t3_halt_req_pc", prog_addr, 8'd1);

    // Stack overflow on the fifth nested call
    do_reset();
    fill_rom();
    for (int c = 0; c < 5; c++) begin
      rom[c*16]     = {OP_NOPO, 8'h00};
      rom[c*16 + 1] = {OP_JMP, 8'((c + 1) * 16)};
    end
    start = 1; tick(); start = 0;
    repeat (9) tick();
    check("t4_pc_5th", prog_addr, 8'h41);
    check("t4_sp_full", sp, 3'd4);
    check("t4_i_5th", i, OP_JMP);
    tick();
    check("t4_err", err, 1'b1);
    check("t4_i_nopo", i, OP_NOPO);
    check("t4_io_zero", io_addr, 8'h00);
    check("t4_sp_keep", sp, 3'd4);
    step = 1; tick(); step = 0;
    check("t4_step_ignored", err, 1'b1);
    start = 1; tick(); start = 0;
    check("t4_err_clr", err, 1'b0);
    check("t4_pc_zero", prog_addr, 8'd0);
    check("t4_sp_zero", sp, 3'd0);
    halt_req = 1; tick(); halt_req = 0;

    // Single step, halt_req blocking, start beating step
    do_reset();
    fill_rom();
    rom[6] = {OP_NOPF, 8'h00};
    start = 1; tick(); start = 0;
    for (int n = 0; n < 30 && !halted; n++) tick();
    check("t5_halted", halted, 1'b1);
    check("t5_pc7", prog_addr, 8'd7);
    step = 1; tick(); step = 0;
    check("t5_step_run", running, 1'b1);
    check("t5_step_pc", prog_addr, 8'd7);
    check("t5_step_i", i, OP_LD);
    check("t5_halted_clr", halted, 1'b0);
    tick();
    check("t5_step_done", running, 1'b0);
    check("t5_pc8", prog_addr, 8'd8);
    tick();
    check("t5_pc8_hold", prog_addr, 8'd8);
    halt_req = 1; start = 1; tick(); start = 0;
    check("t5_halt_blocks_start", running, 1'b0);
    step = 1; tick(); step = 0;
    check("t5_halt_blocks_step", running, 1'b0);
    check("t5_pc8_blocked", prog_addr, 8'd8);
    halt_req = 0;
    start = 1; step = 1; tick(); start = 0; step = 0;
    check("t5_both_run", running, 1'b1);
    tick();
    check("t5_start_wins", running, 1'b1);
    check("t5_pc9", prog_addr, 8'd9);
    halt_req = 1; tick(); halt_req = 0;
    check("t5_halt_stop", running, 1'b0);
    check("t5_pc10", prog_addr, 8'd10);

    // PC wrap on a 4-bit counter, then asynchronous reset mid-run
    do_reset();
    start4 = 1; tick(); start4 = 0;
    check("t6_pc0", prog_addr4, 4'd0);
    repeat (15) tick();
    check("t6_pc15", prog_addr4, 4'd15);
    tick();
    check("t6_wrap", prog_addr4, 4'd0);
    check("t6_run", running4, 1'b1);
    tick(); tick();
    check("t6_pc2", prog_addr4, 4'd2);
    #2 rst = 0;
    #1;
    check("t6_rst_pc", prog_addr4, 4'd0);
    check("t6_rst_i", i4, OP_NOPO);
    check("t6_rst_run", running4, 1'b0);
    #1 rst = 1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
